riscv_retire_checker: RTL and testbench

- Synthesizable self-check stage directly downstream of the RISC-V core top. Consumes NUM_INST, OUTPUT_PORT and HALT.
- Holds a table of (instruction count, expected OUTPUT_PORT) pairs and checks them in order as instructions retire.
- Reports pass, fail or timeout through sticky status outputs, so the pass/fail decision is made in hardware (FPGA runs and gate-level simulation), not by the bench.

---
 rtl/riscv_retire_checker.sv | 185 ++++++++++++++++++
 tb/tb_riscv_retire_checker.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/riscv_retire_checker.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// riscv_retire_checker: in-order retire checkpoint checker with sticky
// pass/fail/timeout status. Macro RETIRE_CHK_SIG_EN adds a SIGNATURE output.
// Rev 1.0
// ============================================================================
module riscv_retire_checker #(
  parameter int NUM_TEST       = 22,
  parameter int IDXW           = 5,
  parameter int TIMEOUT_CYCLES = 1000000
) (
  input  logic            CLK,
  input  logic            RST,
  input  logic            START,
  input  logic            TBL_WE,
  input  logic [IDXW-1:0] TBL_WA,
  input  logic [31:0]     TBL_WNUM,
  input  logic [31:0]     TBL_WANS,
  input  logic [31:0]     NUM_INST,
  input  logic [31:0]     OUTPUT_PORT,
  input  logic            HALT,
  output logic            BUSY,
  output logic            DONE,
  output logic            PASS,
  output logic            FAIL,
  output logic            TIMEOUT,
  output logic [1:0]      FAIL_CODE,
  output logic [IDXW-1:0] FAIL_IDX,
  output logic [31:0]     FAIL_GOT,
  output logic [IDXW-1:0] PASS_CNT,
`ifdef RETIRE_CHK_SIG_EN
  output logic [31:0]     SIGNATURE,
`endif
  output logic [31:0]     CYCLE_CNT
);

  localparam logic [IDXW-1:0] LAST_PTR = IDXW'(NUM_TEST);
  localparam logic [31:0]     TO_LAST  = 32'(TIMEOUT_CYCLES - 1);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_RUN     = 3'd1,
    S_PASS    = 3'd2,
    S_FAIL    = 3'd3,
    S_TIMEOUT = 3'd4
  } state_t;

  state_t          state_q, state_d;
  logic [IDXW-1:0] ptr_q, ptr_d;
  logic [31:0]     cyc_q, cyc_d;
  logic [1:0]      code_q, code_d;
  logic [IDXW-1:0] fidx_q, fidx_d;
  logic [31:0]     fgot_q, fgot_d;
`ifdef RETIRE_CHK_SIG_EN
  logic [31:0]     sig_q, sig_d;
`endif

  logic [31:0]     tbl_num_q [NUM_TEST];
  logic [31:0]     tbl_ans_q [NUM_TEST];
  logic            tbl_wr;
  logic            in_range;
  logic [IDXW-1:0] rd_idx;
  logic [31:0]     e_num, e_ans;
  logic            failed;
  logic [1:0]      new_code;
  logic [IDXW-1:0] ptr_post;

  assign tbl_wr   = (state_q == S_IDLE) && TBL_WE && (TBL_WA < LAST_PTR);
  assign in_range = (ptr_q < LAST_PTR);
  // ptr saturates at NUM_TEST, so clamp the read index to stay inside the table
  assign rd_idx   = in_range ? ptr_q : '0;
  assign e_num    = tbl_num_q[rd_idx];
  assign e_ans    = tbl_ans_q[rd_idx];

  always_ff @(posedge CLK) begin
    if (tbl_wr) begin
      tbl_num_q[TBL_WA] <= TBL_WNUM;
      tbl_ans_q[TBL_WA] <= TBL_WANS;
    end
  end

  always_comb begin
    state_d  = state_q;
    ptr_d    = ptr_q;
    cyc_d    = cyc_q;
    code_d   = code_q;
    fidx_d   = fidx_q;
    fgot_d   = fgot_q;
`ifdef RETIRE_CHK_SIG_EN
    sig_d    = sig_q;
`endif
    failed   = 1'b0;
    new_code = 2'd0;
    ptr_post = ptr_q;

    case (state_q)
      S_IDLE: begin
        if (START) state_d = S_RUN;
      end
      S_RUN: begin
        cyc_d = cyc_q + 32'd1;
        if (cyc_q == TO_LAST) begin
          state_d = S_TIMEOUT;
        end else begin
          if (in_range && (NUM_INST == e_num)) begin
            if (OUTPUT_PORT == e_ans) begin
              ptr_post = ptr_q + 1'b1;
`ifdef RETIRE_CHK_SIG_EN
              sig_d = {sig_q[30:0], sig_q[31]} ^ OUTPUT_PORT;
`endif
            end else begin
              failed   = 1'b1;
              new_code = 2'd1;
            end
          end else if (in_range && (NUM_INST > e_num)) begin
            failed   = 1'b1;
            new_code = 2'd2;
          end

          // A checkpoint failure in this cycle outranks HALT
          if (failed) begin
            state_d = S_FAIL;
            code_d  = new_code;
            fidx_d  = ptr_q;
            fgot_d  = OUTPUT_PORT;
          end else begin
            ptr_d = ptr_post;
            if (HALT) begin
              if (ptr_post == LAST_PTR) begin
                state_d = S_PASS;
              end else begin
                state_d = S_FAIL;
                code_d  = 2'd3;
                fidx_d  = ptr_post;
                fgot_d  = OUTPUT_PORT;
              end
            end
          end
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q <= S_IDLE;
      ptr_q   <= '0;
      cyc_q   <= '0;
      code_q  <= '0;
      fidx_q  <= '0;
      fgot_q  <= '0;
`ifdef RETIRE_CHK_SIG_EN
      sig_q   <= '0;
`endif
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      cyc_q   <= cyc_d;
      code_q  <= code_d;
      fidx_q  <= fidx_d;
      fgot_q  <= fgot_d;
`ifdef RETIRE_CHK_SIG_EN
      sig_q   <= sig_d;
`endif
    end
  end

  assign BUSY      = (state_q == S_RUN);
  assign PASS      = (state_q == S_PASS);
  assign FAIL      = (state_q == S_FAIL);
  assign TIMEOUT   = (state_q == S_TIMEOUT);
  assign DONE      = PASS | FAIL | TIMEOUT;
  assign FAIL_CODE = code_q;
  assign FAIL_IDX  = fidx_q;
  assign FAIL_GOT  = fgot_q;
  assign PASS_CNT  = ptr_q;
  assign CYCLE_CNT = cyc_q;
`ifdef RETIRE_CHK_SIG_EN
  assign SIGNATURE = sig_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_riscv_retire_checker.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// tb_riscv_retire_checker: scoreboard bench for riscv_retire_checker.
// Rev 1.0
// ============================================================================
module tb_riscv_retire_checker;
  localparam int NT = 22;
  localparam int IW = 5;
  localparam int TO = 50;

  logic          clk = 1'b0;
  logic          rst, start, tbl_we, halt;
  logic [IW-1:0] tbl_wa;
  logic [31:0]   tbl_wnum, tbl_wans, num_inst, out_port;
  logic          busy, done, pass, fail, tmo;
  logic [1:0]    fail_code;
  logic [IW-1:0] fail_idx, pass_cnt;
  logic [31:0]   fail_got, cycle_cnt;
`ifdef RETIRE_CHK_SIG_EN
  logic [31:0]   signature;
`endif

  always #5 clk = ~clk;

  riscv_retire_checker #(.NUM_TEST(NT), .IDXW(IW), .TIMEOUT_CYCLES(TO)) dut (
    .CLK(clk), .RST(rst), .START(start), .TBL_WE(tbl_we), .TBL_WA(tbl_wa),
    .TBL_WNUM(tbl_wnum), .TBL_WANS(tbl_wans), .NUM_INST(num_inst),
    .OUTPUT_PORT(out_port), .HALT(halt), .BUSY(busy), .DONE(done),
    .PASS(pass), .FAIL(fail), .TIMEOUT(tmo), .FAIL_CODE(fail_code),
    .FAIL_IDX(fail_idx), .FAIL_GOT(fail_got), .PASS_CNT(pass_cnt),
`ifdef RETIRE_CHK_SIG_EN
    .SIGNATURE(signature),
`endif
    .CYCLE_CNT(cycle_cnt)
  );

  typedef struct {
    string       tag;
    logic        busy, done, pass, fail, tmo;
    logic [1:0]  code;
    int          idx;
    logic        chk_got;
    logic [31:0] got;
    int          pcnt;
    logic        chk_cyc;
    int          cyc;
  } exp_t;

  exp_t sb[$];
  int   n_chk  = 0;
  int   n_pass = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  function automatic logic [31:0] ans(input int k);
    return 32'(k * k + 1);
  endfunction

  task automatic push_rec(input string tag, input logic b, input logic d, input logic p,
                          input logic f, input logic t, input logic [1:0] code, input int idx,
                          input logic cg, input logic [31:0] got, input int pcnt,
                          input logic cc, input int cyc);
    exp_t e;
    e.tag = tag; e.busy = b; e.done = d; e.pass = p; e.fail = f; e.tmo = t;
    e.code = code; e.idx = idx; e.chk_got = cg; e.got = got; e.pcnt = pcnt;
    e.chk_cyc = cc; e.cyc = cyc;
    sb.push_back(e);
  endtask

  task automatic compare_front();
    exp_t e;
    if (sb.size() == 0) begin
      check("sb_empty", 32'd0, 32'd1);
      return;
    end
    e = sb.pop_front();
    check({e.tag, ".busy"}, 32'(busy), 32'(e.busy));
    check({e.tag, ".done"}, 32'(done), 32'(e.done));
    check({e.tag, ".pass"}, 32'(pass), 32'(e.pass));
    check({e.tag, ".fail"}, 32'(fail), 32'(e.fail));
    check({e.tag, ".timeout"}, 32'(tmo), 32'(e.tmo));
    check({e.tag, ".code"}, 32'(fail_code), 32'(e.code));
    check({e.tag, ".idx"}, 32'(fail_idx), 32'(e.idx));
    check({e.tag, ".pass_cnt"}, 32'(pass_cnt), 32'(e.pcnt));
    if (e.chk_got) check({e.tag, ".got"}, fail_got, e.got);
    if (e.chk_cyc) check({e.tag, ".cycles"}, cycle_cnt, 32'(e.cyc));
  endtask

  // All drive/sample points sit on the falling edge
  task automatic step(input logic [31:0] n, input logic [31:0] o, input logic h);
    num_inst = n; out_port = o; halt = h;
    @(negedge clk);
  endtask

  task automatic start_run();
    start = 1'b1; num_inst = '0; out_port = '0; halt = 1'b0;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic do_reset();
    start = 1'b0; halt = 1'b0; num_inst = '0; out_port = '0; tbl_we = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic wait_done();
    for (int i = 0; i < 100 && !done; i++) @(negedge clk);
    if (!done) check("done_wait", 32'd0, 32'd1);
  endtask

  task automatic full_pass_run(input string tag);
    start_run();
    for (int k = 1; k <= NT; k++) step(32'(k), ans(k - 1), 1'b0);
    step(32'(NT), ans(NT - 1), 1'b1);
    push_rec(tag, 0, 1, 1, 0, 0, 2'd0, 0, 1, 32'd0, NT, 1, NT + 1);
    wait_done();
    compare_front();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    rst = 1'b1; start = 1'b0; tbl_we = 1'b0; tbl_wa = '0; tbl_wnum = '0;
    tbl_wans = '0; num_inst = '0; out_port = '0; halt = 1'b0;
    @(negedge clk);
    push_rec("reset", 0, 0, 0, 0, 0, 2'd0, 0, 1, 32'd0, 0, 1, 0);
    compare_front();
    rst = 1'b0;

    for (int k = 0; k < NT; k++) begin
      tbl_we = 1'b1; tbl_wa = IW'(k); tbl_wnum = 32'(k + 1); tbl_wans = ans(k);
      @(negedge clk);
    end
    tbl_we = 1'b0;

    full_pass_run("pass");

    // Terminal state must ignore START and table writes
    start = 1'b1; tbl_we = 1'b1; tbl_wa = 5'd5; tbl_wnum = '0; tbl_wans = '0;
    @(negedge clk);
    start = 1'b0; tbl_we = 1'b0;
    @(negedge clk);
    push_rec("sticky", 0, 1, 1, 0, 0, 2'd0, 0, 1, 32'd0, NT, 1, NT + 1);
    compare_front();
    do_reset();

    start_run();
    step(32'd1, ans(0), 1'b0);
    step(32'd2, ans(1), 1'b0);
    step(32'd3, 32'h6, 1'b0);
    push_rec("mismatch", 0, 1, 0, 1, 0, 2'd1, 2, 1, 32'h6, 2, 0, 0);
    wait_done();
    compare_front();
    do_reset();

    start_run();
    for (int k = 1; k <= 4; k++) step(32'(k), ans(k - 1), 1'b0);
    step(32'd6, ans(5), 1'b0);
    push_rec("skip", 0, 1, 0, 1, 0, 2'd2, 4, 1, ans(5), 4, 0, 0);
    wait_done();
    compare_front();
    do_reset();

    start_run();
    for (int k = 1; k <= 9; k++) step(32'(k), ans(k - 1), 1'b0);
    step(32'd10, ans(9), 1'b1);
    push_rec("early_halt", 0, 1, 0, 1, 0, 2'd3, 10, 0, 32'd0, 10, 0, 0);
    wait_done();
    compare_front();
    do_reset();

    start_run();
    for (int k = 1; k < NT; k++) step(32'(k), ans(k - 1), 1'b0);
    step(32'(NT), ans(NT - 1), 1'b1);
    push_rec("halt_with_last", 0, 1, 1, 0, 0, 2'd0, 0, 1, 32'd0, NT, 1, NT);
    wait_done();
    compare_front();
    do_reset();

    start_run();
    for (int i = 0; i < 100 && cycle_cnt != 32'(TO - 1); i++) @(negedge clk);
    check("pre_timeout.cycles", cycle_cnt, 32'(TO - 1));
    check("pre_timeout.timeout", 32'(tmo), 32'd0);
    @(negedge clk);
    push_rec("timeout", 0, 1, 0, 0, 1, 2'd0, 0, 1, 32'd0, 0, 1, TO);
    compare_front();
    @(negedge clk);
    check("timeout_hold.cycles", cycle_cnt, 32'(TO));
    do_reset();

    // Mid-RUN table write attempt on entry 0, then asynchronous reset
    start_run();
    tbl_we = 1'b1; tbl_wa = '0; tbl_wnum = 32'd99; tbl_wans = 32'hdead;
    for (int k = 1; k <= 7; k++) step(32'(k), ans(k - 1), 1'b0);
    check("mid_run.pass_cnt", 32'(pass_cnt), 32'd7);
    tbl_we = 1'b0;
    #2 rst = 1'b1;
    #1;
    push_rec("async_rst", 0, 0, 0, 0, 0, 2'd0, 0, 1, 32'd0, 0, 1, 0);
    compare_front();
    @(negedge clk);
    rst = 1'b0;
    halt = 1'b0; num_inst = '0; out_port = '0;

    full_pass_run("rerun");

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
`default_nettype wire
